dut_job_sequencer: RTL and testbench

Controller that sequences one dut job end to end. It programs one configuration register over cfg, issues the length command, then streams len bytes from a source into din while draining len bytes from dout to a sink. Optionally it reads back a status register before reporting completion. It sits between the host/job queue and the dut, so host logic never drives dut methods directly.

---
 rtl/dut_job_sequencer_pkg.sv | 24 ++
 rtl/dut_job_watchdog.sv | 34 +++
 rtl/dut_job_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_dut_job_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_job_sequencer_pkg.sv
// Shared types and defaults for the dut job sequencer.
// Contents: FSM state enum, cfg opcode constants, default parameter widths.
package dut_job_sequencer_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_CFG_AW  = 8;
  localparam int unsigned DEF_CFG_DW  = 32;
  localparam int unsigned DEF_TIMEOUT = 1024;

  localparam logic CFG_OP_WR = 1'b1;
  localparam logic CFG_OP_RD = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG_WR   = 3'd1,
    ST_LEN      = 3'd2,
    ST_STREAM   = 3'd3,
    ST_STAT_CHK = 3'd4,
    ST_RD_STAT  = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

endpackage

// File: rtl/dut_job_watchdog.sv
// Inactivity watchdog for the job sequencer.
// Ports: clk, rst_n; clr (any method fire or state change) zeroes the count;
// kick advances it while in a waiting state; expire_c flags that the count
// has reached TIMEOUT-1 in a waiting state.
module dut_job_watchdog
  import dut_job_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic kick,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt_q;

  // Idle-cycle counter; the FSM leaves the waiting state on expiry, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (kick) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = kick && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dut_job_sequencer.sv
// Sequences one dut job: cfg write, len command, byte stream in/out, optional
// status read, then a one-cycle done pulse.
// Ports:
//   job_*           : job descriptor handshake (job_ready high only in IDLE)
//   busy/done/err   : status (err sticky until err_clr while in ERR)
//   result          : last status register read
//   src_* / snk_*   : byte source feeding din, byte sink drained from dout
//   din/dout/len/cfg: dut method ports; every *_en is qualified by its *_rdy
module dut_job_sequencer
  import dut_job_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CFG_AW  = DEF_CFG_AW,
  parameter int unsigned CFG_DW  = DEF_CFG_DW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_len,
  input  logic [CFG_AW-1:0] job_cfg_addr,
  input  logic [CFG_DW-1:0] job_cfg_data,
  input  logic              job_stat_rd,
  input  logic [CFG_AW-1:0] job_stat_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              err_clr,
  output logic [CFG_DW-1:0] result,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              snk_valid,
  output logic [DATA_W-1:0] snk_data,
  input  logic              snk_ready,
  output logic [DATA_W-1:0] din_value,
  output logic              din_en,
  input  logic              din_rdy,
  output logic              dout_en,
  input  logic [DATA_W-1:0] dout_value,
  input  logic              dout_rdy,
  output logic [DATA_W-1:0] len_value,
  output logic              len_en,
  input  logic              len_rdy,
  output logic [CFG_AW-1:0] cfg_address,
  output logic [CFG_DW-1:0] cfg_data_in,
  output logic              cfg_op,
  output logic              cfg_en,
  input  logic [CFG_DW-1:0] cfg_data_out,
  input  logic              cfg_rdy
);

  state_t            state_q, state_n;
  logic [DATA_W-1:0] in_cnt_q, in_cnt_n;
  logic [DATA_W-1:0] out_cnt_q, out_cnt_n;
  logic [DATA_W-1:0] len_q;
  logic [CFG_AW-1:0] cfg_addr_q;
  logic [CFG_DW-1:0] cfg_data_q;
  logic              stat_rd_q;
  logic [CFG_AW-1:0] stat_addr_q;
  logic [CFG_DW-1:0] result_q;
  logic              err_q;
  logic              wd_kick;
  logic              wd_clr;
  logic              wd_expire_c;
  logic              any_fire;

  dut_job_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .kick     (wd_kick),
    .expire_c (wd_expire_c)
  );

  // Method enables already include their rdy, so en alone means a fire.
  assign any_fire = cfg_en | len_en | din_en | dout_en;
  assign wd_clr   = any_fire | (state_n != state_q);

  // Next-state and method/handshake decode.
  always_comb begin
    state_n     = state_q;
    in_cnt_n    = in_cnt_q;
    out_cnt_n   = out_cnt_q;
    job_ready   = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;
    err         = err_q;
    result      = result_q;
    wd_kick     = 1'b0;
    cfg_en      = 1'b0;
    cfg_op      = CFG_OP_RD;
    cfg_address = cfg_addr_q;
    cfg_data_in = cfg_data_q;
    len_en      = 1'b0;
    len_value   = len_q;
    din_en      = 1'b0;
    din_value   = src_data;
    src_ready   = 1'b0;
    snk_valid   = 1'b0;
    snk_data    = dout_value;
    dout_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_n = ST_CFG_WR;
      end
      ST_CFG_WR: begin
        wd_kick = 1'b1;
        cfg_op  = CFG_OP_WR;
        cfg_en  = cfg_rdy;
        if (cfg_rdy)          state_n = ST_LEN;
        else if (wd_expire_c) state_n = ST_ERR;
      end
      ST_LEN: begin
        wd_kick = 1'b1;
        len_en  = len_rdy;
        if (len_rdy) begin
          in_cnt_n  = '0;
          out_cnt_n = '0;
          state_n   = (len_q == '0) ? ST_STAT_CHK : ST_STREAM;
        end else if (wd_expire_c) begin
          state_n = ST_ERR;
        end
      end
      ST_STREAM: begin
        wd_kick   = 1'b1;
        din_en    = (in_cnt_q < len_q) && src_valid && din_rdy;
        src_ready = din_en;
        snk_valid = (out_cnt_q < len_q) && dout_rdy;
        dout_en   = snk_valid && snk_ready;
        if (din_en)  in_cnt_n  = in_cnt_q + DATA_W'(1);
        if (dout_en) out_cnt_n = out_cnt_q + DATA_W'(1);
        // Look at post-fire counts so simultaneous final fires exit this edge.
        if ((in_cnt_n == len_q) && (out_cnt_n == len_q)) state_n = ST_STAT_CHK;
        else if (!din_en && !dout_en && wd_expire_c)      state_n = ST_ERR;
      end
      ST_STAT_CHK: begin
        state_n = stat_rd_q ? ST_RD_STAT : ST_DONE;
      end
      ST_RD_STAT: begin
        wd_kick     = 1'b1;
        cfg_address = stat_addr_q;
        cfg_en      = cfg_rdy;
        if (cfg_rdy)          state_n = ST_DONE;
        else if (wd_expire_c) state_n = ST_ERR;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      ST_ERR: begin
        if (err_clr) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, stream counters, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      in_cnt_q  <= in_cnt_n;
      out_cnt_q <= out_cnt_n;
      err_q     <= (state_n == ST_ERR);
    end
  end

  // Job descriptor capture and status result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      stat_rd_q   <= 1'b0;
      stat_addr_q <= '0;
      result_q    <= '0;
    end else begin
      if (job_valid && job_ready) begin
        len_q       <= job_len;
        cfg_addr_q  <= job_cfg_addr;
        cfg_data_q  <= job_cfg_data;
        stat_rd_q   <= job_stat_rd;
        stat_addr_q <= job_stat_addr;
      end
      if ((state_q == ST_RD_STAT) && cfg_rdy) result_q <= cfg_data_out;
    end
  end

endmodule

// File: tb/tb_dut_job_sequencer.sv
// Self-checking bench for dut_job_sequencer: the bench plays host, byte
// source, byte sink and the dut itself, and compares whole-job outcomes
// (transaction counts, byte order, result, done timing) with expectations.
module tb_dut_job_sequencer;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid, job_ready;
  logic [7:0]  job_len;
  logic [7:0]  job_cfg_addr;
  logic [31:0] job_cfg_data;
  logic        job_stat_rd;
  logic [7:0]  job_stat_addr;
  logic        busy, done, err, err_clr;
  logic [31:0] result;
  logic        src_valid, src_ready;
  logic [7:0]  src_data;
  logic        snk_valid, snk_ready;
  logic [7:0]  snk_data;
  logic [7:0]  din_value;
  logic        din_en, din_rdy;
  logic        dout_en, dout_rdy;
  logic [7:0]  dout_value;
  logic [7:0]  len_value;
  logic        len_en, len_rdy;
  logic [7:0]  cfg_address;
  logic [31:0] cfg_data_in, cfg_data_out;
  logic        cfg_op, cfg_en, cfg_rdy;

  dut_job_sequencer #(
    .DATA_W(8), .CFG_AW(8), .CFG_DW(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_cfg_addr(job_cfg_addr), .job_cfg_data(job_cfg_data),
    .job_stat_rd(job_stat_rd), .job_stat_addr(job_stat_addr),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr), .result(result),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state for the current job.
  logic [7:0]  src_q[$], src_exp[$], din_got[$];
  logic [7:0]  dq[$], dut_exp[$], snk_got[$];
  int          n_cfg_wr, n_cfg_rd, n_len, n_done, viol;
  logic [7:0]  got_cfg_addr, got_len, got_rd_addr;
  logic [31:0] got_cfg_data;
  bit          rd_after_stream;
  int          sample_idx, last_fire_idx, done_idx, stall_cnt;
  int          cur_len, hold_at;
  bit          rand_mode, hold_din, job_pending, clr_req;
  logic [31:0] stat_val, exp_result;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit coin();
    return rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // One clock: drive at the falling edge, observe 1ns later, log what fires next edge.
  task automatic step();
    logic [7:0] b;
    bit fire;
    @(negedge clk);
    job_valid    = job_pending;
    src_valid    = (src_q.size() > 0) && coin();
    src_data     = (src_q.size() > 0) ? src_q[0] : 8'h00;
    din_rdy      = !hold_din && coin();
    dout_rdy     = (dq.size() > 0) && coin();
    dout_value   = (dq.size() > 0) ? dq[0] : 8'h00;
    snk_ready    = coin();
    len_rdy      = coin();
    cfg_rdy      = coin();
    cfg_data_out = stat_val;
    err_clr      = clr_req || (rand_mode && ($urandom_range(0, 7) == 0));
    #1;
    sample_idx++;
    if (din_en && !din_rdy)   viol++;
    if (src_ready !== din_en) viol++;
    if (dout_en && !dout_rdy) viol++;
    if (snk_valid && !dout_rdy) viol++;
    if (dout_en && !(snk_valid && snk_ready)) viol++;
    if (len_en && !len_rdy)   viol++;
    if (cfg_en && !cfg_rdy)   viol++;
    fire = 1'b0;
    if (job_valid && job_ready) job_pending = 1'b0;
    if (cfg_en && cfg_rdy) begin
      fire = 1'b1;
      if (cfg_op) begin
        n_cfg_wr++;
        got_cfg_addr = cfg_address;
        got_cfg_data = cfg_data_in;
      end else begin
        n_cfg_rd++;
        got_rd_addr = cfg_address;
        rd_after_stream = (snk_got.size() == cur_len) && (din_got.size() == cur_len);
      end
    end
    if (len_en && len_rdy) begin
      fire = 1'b1;
      n_len++;
      got_len = len_value;
      for (int i = 0; i < int'(len_value); i++) begin
        b = 8'($urandom);
        dq.push_back(b);
        dut_exp.push_back(b);
      end
    end
    if (din_en && din_rdy) begin
      fire = 1'b1;
      din_got.push_back(din_value);
      if (src_q.size() > 0) src_q.delete(0);
      if (int'(din_got.size()) == hold_at) hold_din = 1'b1;
    end
    if (dout_en && dout_rdy) begin
      fire = 1'b1;
      snk_got.push_back(snk_data);
      if (dq.size() > 0) dq.delete(0);
    end
    if (fire) begin
      last_fire_idx = sample_idx;
      stall_cnt = 0;
    end else if (busy && !err) begin
      stall_cnt++;
    end
    if (done) begin
      n_done++;
      done_idx = sample_idx;
    end
  endtask

  task automatic start_job(input int len, input logic [7:0] caddr, input logic [31:0] cdata,
                           input bit srd, input logic [7:0] saddr, input logic [31:0] status,
                           input bit rnd);
    src_q.delete(); src_exp.delete(); din_got.delete();
    dq.delete(); dut_exp.delete(); snk_got.delete();
    n_cfg_wr = 0; n_cfg_rd = 0; n_len = 0; n_done = 0; viol = 0;
    rd_after_stream = 1'b0; stall_cnt = 0;
    last_fire_idx = 0; done_idx = 0;
    for (int i = 0; i < len; i++) begin
      src_q.push_back(8'($urandom));
      src_exp.push_back(src_q[i]);
    end
    stat_val      = status;
    rand_mode     = rnd;
    cur_len       = len;
    job_len       = 8'(len);
    job_cfg_addr  = caddr;
    job_cfg_data  = cdata;
    job_stat_rd   = srd;
    job_stat_addr = saddr;
    job_pending   = 1'b1;
  endtask

  task automatic finish_job(input string tag, input bit srd, input logic [7:0] caddr,
                            input logic [31:0] cdata, input logic [7:0] saddr);
    for (int c = 0; c < 4000 && n_done == 0; c++) step();
    check_eq({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
    rand_mode = 1'b0;
    repeat (3) step();
    check_eq({tag, "_done_once"}, 64'(n_done), 64'd1);
    check_eq({tag, "_cfg_wr_n"}, 64'(n_cfg_wr), 64'd1);
    check_eq({tag, "_cfg_addr"}, 64'(got_cfg_addr), 64'(caddr));
    check_eq({tag, "_cfg_data"}, 64'(got_cfg_data), 64'(cdata));
    check_eq({tag, "_len_n"}, 64'(n_len), 64'd1);
    check_eq({tag, "_len_val"}, 64'(got_len), 64'(cur_len));
    check_eq({tag, "_din_n"}, 64'(din_got.size()), 64'(cur_len));
    check_eq({tag, "_dout_n"}, 64'(snk_got.size()), 64'(cur_len));
    for (int i = 0; i < cur_len && i < int'(din_got.size()); i++)
      check_eq({tag, "_din_byte"}, 64'(din_got[i]), 64'(src_exp[i]));
    for (int i = 0; i < cur_len && i < int'(snk_got.size()) && i < int'(dut_exp.size()); i++)
      check_eq({tag, "_snk_byte"}, 64'(snk_got[i]), 64'(dut_exp[i]));
    check_eq({tag, "_stat_rd_n"}, 64'(n_cfg_rd), 64'(srd));
    if (srd) begin
      check_eq({tag, "_stat_addr"}, 64'(got_rd_addr), 64'(saddr));
      check_eq({tag, "_stat_order"}, 64'(rd_after_stream), 64'd1);
      exp_result = stat_val;
    end
    check_eq({tag, "_result"}, 64'(result), 64'(exp_result));
    check_eq({tag, "_done_lat"}, 64'(done_idx - last_fire_idx), srd ? 64'd1 : 64'd2);
    check_eq({tag, "_proto_viol"}, 64'(viol), 64'd0);
    check_eq({tag, "_idle"}, 64'({busy, job_ready, err}), 64'b010);
  endtask

  task automatic run_job(input string tag, input int len, input logic [7:0] caddr,
                         input logic [31:0] cdata, input bit srd, input logic [7:0] saddr,
                         input logic [31:0] status, input bit rnd);
    start_job(len, caddr, cdata, srd, saddr, status, rnd);
    finish_job(tag, srd, caddr, cdata, saddr);
  endtask

  initial begin
    rst_n = 1'b0;
    job_valid = 0; job_len = 0; job_cfg_addr = 0; job_cfg_data = 0;
    job_stat_rd = 0; job_stat_addr = 0; err_clr = 0;
    src_valid = 0; src_data = 0; snk_ready = 0; din_rdy = 0;
    dout_value = 0; dout_rdy = 0; len_rdy = 0; cfg_data_out = 0; cfg_rdy = 0;
    sample_idx = 0; hold_at = -1; hold_din = 0; job_pending = 0; clr_req = 0;
    rand_mode = 0; stat_val = 0; exp_result = 0; cur_len = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_status", 64'({busy, done, err}), 64'd0);
    check_eq("rst_en", 64'({cfg_en, len_en, din_en, dout_en, src_ready, snk_valid}), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check_eq("post_rst_ready", 64'({job_ready, busy}), 64'b10);

    run_job("basic4", 4, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0, 1'b0);
    run_job("stat3", 3, 8'($urandom), $urandom, 1'b1, 8'h20, 32'h0000_0003, 1'b0);
    run_job("len0", 0, 8'h44, 32'h1234_5678, 1'b0, 8'h00, 32'h0, 1'b0);
    run_job("stall8", 8, 8'($urandom), $urandom, 1'($urandom), 8'($urandom), $urandom, 1'b1);
    for (int j = 0; j < 6; j++)
      run_job("rnd", int'($urandom_range(0, 12)), 8'($urandom), $urandom, 1'($urandom),
              8'($urandom), $urandom, 1'b1);
    run_job("len255", 255, 8'h7F, 32'hCAFE_F00D, 1'b1, 8'h33, 32'h5A5A_0001, 1'b0);

    // Watchdog: stop din after two bytes and let the job time out.
    start_job(5, 8'h01, 32'h1, 1'b0, 8'h00, 32'h0, 1'b0);
    hold_at = 2;
    for (int c = 0; c < 600 && !err; c++) step();
    check_eq("to_err", 64'(err), 64'd1);
    check_eq("to_cycles", 64'(stall_cnt), 64'(TO));
    check_eq("to_en_off", 64'({cfg_en, len_en, din_en, dout_en, src_ready, snk_valid}), 64'd0);
    check_eq("to_din_n", 64'(din_got.size()), 64'd2);
    repeat (3) step();
    check_eq("to_err_sticky", 64'({err, job_ready}), 64'b10);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    hold_din = 1'b0; hold_at = -1;
    src_q.delete(); dq.delete();
    step();
    check_eq("to_clr", 64'({err, job_ready, busy}), 64'b010);
    run_job("after_to", 6, 8'h55, 32'hA5A5_A5A5, 1'b1, 8'h66, 32'h0BAD_CAFE, 1'b1);

    // Reset in the middle of a stream once two input bytes have been taken.
    start_job(5, 8'h02, 32'h2, 1'b1, 8'h09, 32'hFFFF_FFFF, 1'b0);
    for (int c = 0; c < 200 && din_got.size() < 2; c++) step();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_status", 64'({busy, done, err}), 64'd0);
    check_eq("mid_rst_en", 64'({cfg_en, len_en, din_en, dout_en, src_ready, snk_valid}), 64'd0);
    check_eq("mid_rst_result", 64'(result), 64'd0);
    check_eq("mid_rst_ready", 64'(job_ready), 64'd1);
    repeat (2) @(posedge clk);
    job_pending = 1'b0;
    src_q.delete(); dq.delete();
    @(negedge clk) rst_n = 1'b1;
    exp_result = 32'h0;
    n_done = 0;
    repeat (3) step();
    check_eq("mid_rst_no_done", 64'(n_done), 64'd0);
    check_eq("mid_rst_idle", 64'({busy, job_ready}), 64'b01);
    run_job("after_rst", 5, 8'h77, 32'h0F0F_0F0F, 1'b0, 8'h00, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
